// File: rtl/byte_serializer_pkg.sv
// Shared encodings for the byte serializer and the sequence-detector path it feeds.
package byte_serializer_pkg;

    // Shifter FSM: waiting for a word, or presenting one bit per cycle.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Input buffer depth and the width needed to count 0..FIFO_DEPTH.
    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/ser_fifo2.sv
// Two-entry in-order word buffer between the producer handshake and the shifter.
module ser_fifo2
    import byte_serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage write; contents are only ever read behind a valid count.
    // NOTE: the data array has no reset -- count and pointers decide what is valid, so clearing it adds fanout for nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keeps the count.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + FIFO_CNT_W'(1);
                2'b01:   count <= count - FIFO_CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial converter: buffers words in a 2-deep FIFO and shifts them out
// one bit per cycle, back-to-back, with a frame_start marker on each word's first bit.
module byte_serializer
    import byte_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    ser_state_t             state;
    ser_state_t             state_next;
    logic [CNT_W-1:0]       bit_cnt;
    logic [WIDTH-1:0]       shreg;
    logic                   ready_en;
    logic                   push;
    logic                   pop;
    logic                   last_bit;
    logic                   busy_next;
    logic [WIDTH-1:0]       head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FIFO_CNT_W-1:0]  fifo_count;
    logic [FIFO_CNT_W-1:0]  fifo_count_next;

    // Bit presented first from a freshly loaded word.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Drops the bit just presented so the next one sits at the output end.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // ready_en holds in_ready low until the first edge after reset release.
    assign in_ready        = ready_en && !fifo_full;
    assign push            = in_valid && in_ready;
    assign last_bit        = (bit_cnt == CNT_W'(WIDTH - 1));
    assign fifo_count_next = fifo_count + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
    assign busy_next       = (state_next == SHIFT) || (fifo_count_next != '0);

    ser_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: start on any buffered word, fall back to IDLE after the last bit if nothing waits.
    // NOTE: the default assignment up front keeps every path driven, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty) state_next = SHIFT;
            SHIFT:   if (last_bit && fifo_empty) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM output: pop the FIFO head when idle, or on the last bit to chain words without a bubble.
    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = !fifo_empty;
            SHIFT:   pop = last_bit && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    // Shift datapath and registered outputs; dout/frame_start are zero whenever dout_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en    <= 1'b0;
            bit_cnt     <= '0;
            shreg       <= '0;
            dout        <= 1'b0;
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            busy     <= busy_next;
            if (pop) begin
                shreg       <= advance(head);
                dout        <= first_bit(head);
                dout_valid  <= 1'b1;
                frame_start <= 1'b1;
                bit_cnt     <= '0;
            end else if (state == SHIFT && !last_bit) begin
                shreg       <= advance(shreg);
                dout        <= first_bit(shreg);
                dout_valid  <= 1'b1;
                frame_start <= 1'b0;
                bit_cnt     <= bit_cnt + CNT_W'(1);
            end else begin
                dout        <= 1'b0;
                dout_valid  <= 1'b0;
                frame_start <= 1'b0;
                bit_cnt     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench: an MSB-first and an LSB-first serializer share the same
// stimulus; a timeline model (each word occupies WIDTH output cycles, starting
// no earlier than one edge after acceptance) predicts every output each cycle.
module tb_byte_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;

    logic in_ready_m, dout_m, dv_m, fs_m, busy_m;
    logic in_ready_l, dout_l, dv_l, fs_l, busy_l;

    byte_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready_m),
        .dout        (dout_m),
        .dout_valid  (dv_m),
        .frame_start (fs_m),
        .busy        (busy_m)
    );

    byte_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready_l),
        .dout        (dout_l),
        .dout_valid  (dv_l),
        .frame_start (fs_l),
        .busy        (busy_l)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Model state: edge index, reset tracking and the accepted-word timeline.
    int           cyc        = 0;
    int           ready_edge = 1 << 30;
    bit           in_reset   = 1'b1;
    int           next_free  = 0;
    int           last_start = 0;
    int           acc_q[$];
    int           start_q[$];
    logic [W-1:0] word_q[$];

    // Observed streams for directed checks.
    logic bits_m[$];
    logic bits_l[$];
    int   fs_count = 0;
    int   n_accepted = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Words accepted by edge k that have not yet started shifting.
    function automatic int occ_at(input int k);
        int n = 0;
        foreach (acc_q[i]) if (acc_q[i] <= k && start_q[i] > k) n++;
        return n;
    endfunction

    function automatic bit ready_at(input int k);
        return !in_reset && (k >= ready_edge) && (occ_at(k) < 2);
    endfunction

    task automatic accept(input int edge_idx, input logic [W-1:0] w);
        int s;
        s = (edge_idx + 1 > next_free) ? edge_idx + 1 : next_free;
        acc_q.push_back(edge_idx);
        start_q.push_back(s);
        word_q.push_back(w);
        next_free  = s + W;
        last_start = s;
        n_accepted++;
    endtask

    task automatic model_clear();
        acc_q.delete();
        start_q.delete();
        word_q.delete();
        next_free = 0;
    endtask

    task automatic compare_all();
        bit   ev, eb, er;
        logic em, el, efs;
        int   idx;
        ev = 1'b0; em = 1'b0; el = 1'b0; efs = 1'b0;
        foreach (start_q[i]) begin
            if (cyc >= start_q[i] && cyc < start_q[i] + W) begin
                idx = cyc - start_q[i];
                ev  = 1'b1;
                em  = word_q[i][W-1-idx];
                el  = word_q[i][idx];
                efs = (idx == 0);
            end
        end
        eb = ev || (occ_at(cyc) > 0);
        er = ready_at(cyc);
        check("dout_valid_m",  dv_m,       ev);
        check("dout_m",        dout_m,     em);
        check("frame_start_m", fs_m,       efs);
        check("busy_m",        busy_m,     eb);
        check("in_ready_m",    in_ready_m, er);
        check("dout_valid_l",  dv_l,       ev);
        check("dout_l",        dout_l,     el);
        check("frame_start_l", fs_l,       efs);
        check("busy_l",        busy_l,     eb);
        check("in_ready_l",    in_ready_l, er);
        if (dv_m) bits_m.push_back(dout_m);
        if (dv_l) bits_l.push_back(dout_l);
        if (fs_m) fs_count++;
    endtask

    // One clock: register a handshake in the model, advance an edge, check at the falling edge.
    task automatic step();
        if (in_valid && ready_at(cyc)) accept(cyc + 1, in_data);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic clear_obs();
        bits_m.delete();
        bits_l.delete();
        fs_count = 0;
    endtask

    function automatic logic [31:0] pack_m();
        logic [31:0] v = '0;
        foreach (bits_m[i]) v = {v[30:0], bits_m[i]};
        return v;
    endfunction

    function automatic logic [31:0] pack_l();
        logic [31:0] v = '0;
        foreach (bits_l[i]) v = {v[30:0], bits_l[i]};
        return v;
    endfunction

    task automatic send_word(input logic [W-1:0] w);
        in_data  = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    logic [W-1:0] burst [4];
    int           n_acc;
    bit           saw_stall;
    int           rand_base;

    initial begin
        // Reset held: everything low, including in_ready.
        @(negedge clk);
        compare_all();
        repeat (3) step();
        rst_n      = 1'b1;
        in_reset   = 1'b0;
        ready_edge = cyc + 1;

        // Idle for 20 cycles: no data, ready from the first edge on.
        repeat (20) step();

        // Single word 8'hD0.
        clear_obs();
        send_word(8'hD0);
        repeat (12) step();
        check("d0_len",        bits_m.size(), 8);
        check("d0_bits_msb",   pack_m(), 32'h0000_00D0);
        check("d0_bits_lsb",   pack_l(), 32'h0000_000B);
        check("d0_frames",     fs_count, 1);

        // Back-to-back 8'hD0, 8'h0D: 16 contiguous bits.
        clear_obs();
        send_word(8'hD0);
        send_word(8'h0D);
        repeat (20) step();
        check("b2b_len",       bits_m.size(), 16);
        check("b2b_bits",      pack_m(), 32'h0000_D00D);
        check("b2b_frames",    fs_count, 2);

        // Four words with in_valid held: producer stalls on a full FIFO and holds data.
        clear_obs();
        burst[0] = 8'h3C; burst[1] = 8'hA5; burst[2] = 8'h81; burst[3] = 8'h7E;
        n_acc = 0;
        saw_stall = 1'b0;
        for (int t = 0; t < 100 && n_acc < 4; t++) begin
            bit acc;
            in_data  = burst[n_acc];
            in_valid = 1'b1;
            acc = in_ready_m;
            if (!acc) saw_stall = 1'b1;
            step();
            if (acc) n_acc++;
        end
        in_valid = 1'b0;
        repeat (40) step();
        check("burst_accepts", n_acc, 4);
        check("burst_stalled", saw_stall, 1'b1);
        check("burst_len",     bits_m.size(), 32);
        check("burst_bits",    pack_m(), 32'h3CA5_817E);

        // 8'h0B: LSB-first instance emits 1,1,0,1,0,0,0,0.
        clear_obs();
        send_word(8'h0B);
        repeat (12) step();
        check("lsb_0b_bits",   pack_l(), 32'h0000_00D0);
        check("msb_0b_bits",   pack_m(), 32'h0000_000B);

        // Reset at bit 3 of a word with a second word buffered.
        clear_obs();
        send_word(8'hF3);
        send_word(8'h5A);
        while (cyc < last_start - W + 3) step();
        check("pre_rst_busy", busy_m, 1'b1);
        #1;
        rst_n    = 1'b0;
        in_reset = 1'b1;
        model_clear();
        #1;
        compare_all();
        repeat (2) step();
        rst_n      = 1'b1;
        in_reset   = 1'b0;
        ready_edge = cyc + 1;
        clear_obs();
        repeat (12) step();
        check("post_rst_bits", bits_m.size(), 0);
        send_word(8'h96);
        repeat (12) step();
        check("post_rst_word", pack_m(), 32'h0000_0096);

        // Randomized traffic, stall rule honoured.
        clear_obs();
        rand_base = n_accepted;
        for (int t = 0; t < 400; t++) begin
            if (!(in_valid && !in_ready_m)) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = W'($urandom);
            end
            step();
        end
        in_valid = 1'b0;
        repeat (30) step();
        check("rand_frames",   fs_count, n_accepted - rand_base);
        check("rand_len",      bits_m.size(), (n_accepted - rand_base) * W);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
